// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, fetches from variable-latency instruction memory, drives IF/ID.
// Define FETCH_PERF_CNT_EN to add saturating delivered-instruction and wait-cycle counters.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_INC = 16'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirectPC,
    output logic [15:0] imemAddr,
    output logic        imemRd,
    input  logic [15:0] imemData,
    input  logic        imemDone,
    output logic [15:0] instrOut,
    output logic [15:0] currPCOut,
    output logic [15:0] nextPCOut,
    output logic        fetchValid,
    output logic        halted,
    output logic [15:0] fetchCount,
    output logic [15:0] waitCount
);
    localparam logic [15:0] NOP = 16'h0800;
    typedef enum logic [1:0] {REQ, HOLD, SQUASH, HALT} state_t;
    state_t state, stateNext;
    logic [15:0] pc, pcNext, reqAddr, holdInstr, rawInstr;
    logic offered, delivered, isHalt;
    always_comb begin
        imemRd = state == REQ || state == SQUASH;
        imemAddr = state == SQUASH ? reqAddr : pc;
        rawInstr = state == HOLD ? holdInstr : imemData;
        isHalt = rawInstr[15:11] == 5'b00000;
        offered = (state == REQ && imemDone) || state == HOLD;
        fetchValid = offered && !redirect;
        delivered = fetchValid && !stall;
        instrOut = fetchValid ? rawInstr : NOP;
        currPCOut = pc;
        nextPCOut = pc + PC_INC;
        halted = state == HALT;
        pcNext = redirect ? redirectPC : delivered ? pc + PC_INC : pc;
        // A redirect never abandons an in-flight read: it is drained in SQUASH instead.
        stateNext = state == SQUASH ? (imemDone ? REQ : SQUASH)
                  : state == HALT   ? (redirect ? REQ : HALT)
                  : redirect        ? ((state == REQ && !imemDone) ? SQUASH : REQ)
                  : !offered        ? REQ
                  : stall           ? HOLD
                  : isHalt          ? HALT : REQ;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= REQ;
            pc <= RESET_PC;
            reqAddr <= RESET_PC;
            holdInstr <= NOP;
        end else begin
            state <= stateNext;
            pc <= pcNext;
            if (imemRd) reqAddr <= imemAddr;
            if (state == REQ && stateNext == HOLD) holdInstr <= imemData;
        end
    end
`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetchCount <= '0;
            waitCount <= '0;
        end else begin
            if (delivered && fetchCount != 16'hFFFF) fetchCount <= fetchCount + 16'd1;
            if (imemRd && !imemDone && waitCount != 16'hFFFF) waitCount <= waitCount + 16'd1;
        end
    end
`else
    assign fetchCount = '0;
    assign waitCount = '0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch stimulus against an architectural PC-stream model with a scoreboard.
module tb_fetch_unit;
    logic clk = 0, rst = 1, stall = 0, redirect = 0, imemDone = 0;
    logic [15:0] redirectPC = 0, imemData = 0;
    logic [15:0] imemAddr, instrOut, currPCOut, nextPCOut, fetchCount, waitCount;
    logic imemRd, fetchValid, halted;
    int compared = 0, mismatched = 0;
    logic [15:0] mem [256];
    logic [15:0] expPC [$];
    bit modelHalted = 0, running = 0, busy = 0;
    logic [15:0] busyAddr, tgt, v;
    int waitLeft = 0, modelFetch = 0, modelWait = 0, totalDel = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirectPC(redirectPC),
        .imemAddr(imemAddr), .imemRd(imemRd), .imemData(imemData), .imemDone(imemDone),
        .instrOut(instrOut), .currPCOut(currPCOut), .nextPCOut(nextPCOut),
        .fetchValid(fetchValid), .halted(halted), .fetchCount(fetchCount), .waitCount(waitCount)
    );

    function automatic logic [15:0] memAt(input logic [15:0] a);
        return mem[a[8:1]];
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the expected PC whenever the DUT delivers an instruction.
    always @(negedge clk) begin
        if (running && !rst) begin
            if (redirect) check("redirectSquash", 16'(fetchValid), 16'd0);
            else begin
                check("currPC", currPCOut, expPC[0]);
                check("nextPC", nextPCOut, expPC[0] + 16'd2);
                check("halted", 16'(halted), 16'(modelHalted));
                if (modelHalted) begin
                    check("haltRd", 16'(imemRd), 16'd0);
                    check("haltValid", 16'(fetchValid), 16'd0);
                end
                if (!fetchValid) check("nop", instrOut, 16'h0800);
                else begin
                    check("instr", instrOut, memAt(expPC[0]));
                    if (!stall) begin
                        v = expPC.pop_front();
                        expPC.push_back(v + 16'd2);
                        if (memAt(v) >= 16'h0000 && memAt(v)[15:11] == 5'b00000) modelHalted = 1;
                        modelFetch++;
                        totalDel++;
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            v = 16'($urandom);
            if ($urandom_range(0, 15) == 0) v[15:11] = 5'b00000;
            else if (v[15:11] == 5'b00000) v[15:11] = 5'b00001;
            mem[i] = v;
        end
        expPC.push_back(16'h0000);
        @(posedge clk); #1;
        rst = 0;
        check("rstRd", 16'(imemRd), 16'd1);
        check("rstAddr", imemAddr, 16'h0000);
        check("rstInstr", instrOut, 16'h0800);
        check("rstValid", 16'(fetchValid), 16'd0);
        check("rstHalted", 16'(halted), 16'd0);
        check("rstPC", currPCOut, 16'h0000);
        running = 1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
`ifdef FETCH_PERF_CNT_EN
            check("fetchCount", fetchCount, 16'(modelFetch));
            check("waitCount", waitCount, 16'(modelWait));
`else
            check("fetchCountOff", fetchCount, 16'd0);
            check("waitCountOff", waitCount, 16'd0);
`endif
            if (busy) check("rdHeld", 16'(imemRd), 16'd1);
            if ((!imemRd && !halted && $urandom_range(0, 9) == 0) || $urandom_range(0, 699) == 0) begin
                rst = 1;
                imemDone = 0;
                redirect = 0;
                busy = 0;
                expPC.delete();
                expPC.push_back(16'h0000);
                modelHalted = 0;
                modelFetch = 0;
                modelWait = 0;
            end else begin
                rst = 0;
                if (imemRd) begin
                    if (!busy) begin
                        busy = 1;
                        busyAddr = imemAddr;
                        waitLeft = $urandom_range(0, 1) == 0 ? 0 : int'($urandom_range(1, 3));
                    end else check("addrStable", imemAddr, busyAddr);
                    if (waitLeft == 0) begin
                        imemDone = 1;
                        imemData = memAt(busyAddr);
                        busy = 0;
                    end else begin
                        waitLeft--;
                        imemDone = 0;
                        imemData = 16'($urandom);
                        modelWait++;
                    end
                end else begin
                    busy = 0;
                    imemDone = 0;
                    imemData = 16'($urandom);
                end
                stall = $urandom_range(0, 3) == 0;
                redirect = halted ? $urandom_range(0, 2) == 0 : $urandom_range(0, 11) == 0;
                tgt = $urandom_range(0, 7) == 0 ? 16'hFFFC : {7'd0, 8'($urandom), 1'b0};
                redirectPC = redirect ? tgt : 16'($urandom);
                if (redirect) begin
                    expPC.delete();
                    expPC.push_back(tgt);
                    modelHalted = 0;
                end
            end
            @(posedge clk); #1;
        end
        running = 0;
        check("progress", 16'(totalDel >= 300), 16'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
